reg_file_2r2w: RTL
==================

# reg_file_2r2w

Parametrised register file with two independent read ports and two write ports, per-entry written flags, a synchronous bulk clear, and optional write-to-read bypass and registered read data. It replaces the fixed 2-entry, 16-bit, single-read/single-write register file in the formal register-test suite. It is the storage element for datapath cores that need two operands read and two results retired per cycle.

## Interface
- DATA_W, 16, width of each entry
- ADDR_W, 2, address width; depth = 2**ADDR_W
- BYPASS, 1, 1: a same-cycle write is visible on a matching read port; 0: reads return pre-write contents
- READ_REG, 0, 0: combinational read; 1: read data and valid registered (1-cycle latency)
- ZERO_REG, 0, 1: entry 0 is hardwired to 0, ignores writes, always valid
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- clear  input  1  synchronous clear of all entries and flags
- w0_en  input  1  write port 0 enable
- w0_addr  input  ADDR_W  write port 0 address
- w0_data  input  DATA_W  write port 0 data
- w1_en  input  1  write port 1 enable (priority port)
- w1_addr  input  ADDR_W  write port 1 address
- w1_data  input  DATA_W  write port 1 data
- ra_addr  input  ADDR_W  read port A address
- ra_data  output  DATA_W  read port A data
- ra_valid  output  1  entry at ra_addr has been written since last reset/clear
- rb_addr  input  ADDR_W  read port B address
- rb_data  output  DATA_W  read port B data
- rb_valid  output  1  as ra_valid, for port B

## Operation
- Storage: 2**ADDR_W entries of DATA_W bits, plus one written flag per entry.
- Reset (asynchronous): all entries are 0 and all flags are 0. With ZERO_REG=1, flag 0 reads 1. When READ_REG=1, the registered ra_data/rb_data are 0 and ra_valid/rb_valid are 0.
- Write: on a clock edge with wN_en=1, entry[wN_addr] <= wN_data and flag[wN_addr] <= 1.
- Write collision: w0 and w1 both enabled to the same address -> w1 data is stored, w0 is discarded. Different addresses -> both writes complete in the same cycle.
- Clear: clear=1 zeroes all entries and flags at the edge. Writes enabled in the same cycle are applied after the clear, so the written entries hold the new data with flag=1.
- ZERO_REG=1: writes to address 0 are ignored; reads of address 0 return data 0, valid 1, and no bypass applies.
- Read without bypass: data = entry[addr], valid = flag[addr] as they stand before the current edge.
- Read with BYPASS=1: if a write port is enabled to the same address in the current cycle, the read returns that port's data and valid=1. w1 takes precedence over w0. clear without a matching write forces the bypassed read to data 0, valid 0.
- Ports A and B are fully independent and may read the same address.

## Timing
- READ_REG=0: data and valid are combinational from address, storage, and (when BYPASS=1) the write and clear inputs, with zero latency.
- READ_REG=1: the value the READ_REG=0 path would present in cycle n appears on the outputs in cycle n+1. With BYPASS=0, a write in cycle n is first visible to a read issued in cycle n+1, which returns it in n+2.
- Write-to-read latency with BYPASS=0, READ_REG=0: one cycle (the read sees new data after the edge).
- reset asserted mid-operation immediately forces storage, flags and registered outputs to their reset values. Any write or clear in that cycle is lost. Writes resume on the first edge after reset deasserts.
- No back-pressure: every enabled write completes in one cycle.

## Test plan
- Reset, then read all 4 addresses on both ports -> data 0x0000, valid 0. With READ_REG=1, the registered outputs read 0/0 during reset.
- w0 writes 0xA5A5 to addr 1 and w1 writes 0x5A5A to addr 2 in the same cycle. Next cycle, ra_addr=1 and rb_addr=2 -> 0xA5A5/1 and 0x5A5A/1. Addr 3 still reads 0/0.
- w0 writes 0x1111 and w1 writes 0x2222, both to addr 3 -> stored value 0x2222. With BYPASS=1, a same-cycle read of addr 3 returns 0x2222/1.
- Addr 1 holds 0x00FF. In one cycle, write 0xBEEF to addr 1 and read addr 1 -> BYPASS=1 returns 0xBEEF; BYPASS=0 returns 0x00FF. With READ_REG=1, the same values appear one cycle later.
- All entries written. Assert clear together with a w0 write of 0x1234 to addr 2 -> after the edge, only addr 2 reads 0x1234/1; all other entries read 0/0.
- ZERO_REG=1: write 0xFFFF to addr 0 -> addr 0 reads 0x0000/1. Then assert reset mid-stream while writing addr 1 -> addr 1 reads 0/0 after reset.

Source files
------------

// File: rtl/reg_file_2r2w.sv
// Two-read / two-write register file with per-entry written flags, synchronous
// bulk clear, optional same-cycle write bypass and optional registered reads.
module reg_file_2r2w #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 2,
  parameter int BYPASS   = 1,
  parameter int READ_REG = 0,
  parameter int ZERO_REG = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              w0_en,
  input  logic [ADDR_W-1:0] w0_addr,
  input  logic [DATA_W-1:0] w0_data,
  input  logic              w1_en,
  input  logic [ADDR_W-1:0] w1_addr,
  input  logic [DATA_W-1:0] w1_data,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic              ra_valid,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_flag;
  logic [DATA_W-1:0] w_mem_nxt [DEPTH];
  logic [DEPTH-1:0]  w_flag_nxt;
  logic              w_w0_ok;
  logic              w_w1_ok;
  logic [DATA_W:0]   w_rd_a;
  logic [DATA_W:0]   w_rd_b;

  // Entry 0 of a zero register never accepts a write, so it stays at 0.
  assign w_w0_ok = w0_en && !((ZERO_REG != 0) && (w0_addr == '0));
  assign w_w1_ok = w1_en && !((ZERO_REG != 0) && (w1_addr == '0));

  // Clear first, then w0, then w1 so w1 wins a same-address collision.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_mem_nxt[i]  = clear ? '0 : r_mem[i];
      w_flag_nxt[i] = clear ? 1'b0 : r_flag[i];
    end
    if (w_w0_ok) begin
      w_mem_nxt[w0_addr]  = w0_data;
      w_flag_nxt[w0_addr] = 1'b1;
    end
    if (w_w1_ok) begin
      w_mem_nxt[w1_addr]  = w1_data;
      w_flag_nxt[w1_addr] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_flag <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= w_mem_nxt[i];
      end
      r_flag <= w_flag_nxt;
    end
  end

  // Returns {valid, data} for one read port.
  function automatic logic [DATA_W:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              stored_vld,
    input logic              clr,
    input logic              we0,
    input logic [ADDR_W-1:0] wa0,
    input logic [DATA_W-1:0] wd0,
    input logic              we1,
    input logic [ADDR_W-1:0] wa1,
    input logic [DATA_W-1:0] wd1
  );
    logic [DATA_W:0] res;
    res = {stored_vld, stored};
    if (BYPASS != 0) begin
      if (we1 && (wa1 == addr)) begin
        res = {1'b1, wd1};
      end else if (we0 && (wa0 == addr)) begin
        res = {1'b1, wd0};
      end else if (clr) begin
        res = '0;
      end
    end
    if ((ZERO_REG != 0) && (addr == '0)) begin
      res = {1'b1, {DATA_W{1'b0}}};
    end
    return res;
  endfunction

  assign w_rd_a = read_port(ra_addr, r_mem[ra_addr], r_flag[ra_addr], clear,
                            w0_en, w0_addr, w0_data, w1_en, w1_addr, w1_data);
  assign w_rd_b = read_port(rb_addr, r_mem[rb_addr], r_flag[rb_addr], clear,
                            w0_en, w0_addr, w0_data, w1_en, w1_addr, w1_data);

  generate
    if (READ_REG != 0) begin : g_read_reg
      logic [DATA_W:0] r_rd_a;
      logic [DATA_W:0] r_rd_b;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_rd_a <= '0;
          r_rd_b <= '0;
        end else begin
          r_rd_a <= w_rd_a;
          r_rd_b <= w_rd_b;
        end
      end

      assign {ra_valid, ra_data} = r_rd_a;
      assign {rb_valid, rb_data} = r_rd_b;
    end else begin : g_read_comb
      assign {ra_valid, ra_data} = w_rd_a;
      assign {rb_valid, rb_data} = w_rd_b;
    end
  endgenerate

endmodule
